// File: rtl/demux_2_stream.sv
// Registered 1-to-2 stream demultiplexer: one valid/ready input stream is routed
// per word by i_s into one of two independent 2-entry lane FIFOs with push counters.
module demux_2_stream #(
  parameter int unsigned N  = 64,
  parameter int unsigned CW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [N-1:0]  i_in,
  input  logic          i_s,
  input  logic          i_valid,
  output logic          o_ready,
  output logic [N-1:0]  o_out0,
  output logic          o_valid0,
  input  logic          i_ready0,
  output logic [N-1:0]  o_out1,
  output logic          o_valid1,
  input  logic          i_ready1,
  output logic [CW-1:0] o_cnt0,
  output logic [CW-1:0] o_cnt1
);

  localparam int unsigned LANES = 2;

  logic [N-1:0]  mem    [LANES][2];
  logic [CW-1:0] cnt    [LANES];
  logic [1:0]    level  [LANES];
  logic          rd_ptr [LANES];
  logic          wr_ptr [LANES];

  logic [LANES-1:0] full;
  logic [LANES-1:0] head_valid;
  logic [LANES-1:0] lane_ready;
  logic [LANES-1:0] push;
  logic [LANES-1:0] pop;
  logic             accept;

  // Ready looks only at i_s and registered fill levels, so no consumer-ready
  // or i_valid path ever reaches o_ready.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      full[l]       = (level[l] == 2'd2);
      head_valid[l] = (level[l] != 2'd0);
    end
  end

  assign o_ready       = i_s ? !full[1] : !full[0];
  assign accept        = i_valid && o_ready;
  assign lane_ready[0] = i_ready0;
  assign lane_ready[1] = i_ready1;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      push[l] = accept && (i_s == l[0]);
      pop[l]  = head_valid[l] && lane_ready[l];
    end
  end

  // NOTE: storage is reset along with the control state because the head entry
  // is driven onto o_outX even when the lane is empty, and it must read 0 after reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int l = 0; l < LANES; l++) begin
        mem[l][0] <= '0;
        mem[l][1] <= '0;
        cnt[l]    <= '0;
        level[l]  <= 2'd0;
        rd_ptr[l] <= 1'b0;
        wr_ptr[l] <= 1'b0;
      end
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (push[l]) begin
          mem[l][wr_ptr[l]] <= i_in;
          wr_ptr[l]         <= ~wr_ptr[l];
          cnt[l]            <= cnt[l] + CW'(1);
        end
        if (pop[l]) begin
          rd_ptr[l] <= ~rd_ptr[l];
        end
        // Simultaneous push and pop leaves the level unchanged.
        case ({push[l], pop[l]})
          2'b10:   level[l] <= level[l] + 2'd1;
          2'b01:   level[l] <= level[l] - 2'd1;
          default: level[l] <= level[l];
        endcase
      end
    end
  end

  assign o_out0   = mem[0][rd_ptr[0]];
  assign o_out1   = mem[1][rd_ptr[1]];
  assign o_valid0 = head_valid[0];
  assign o_valid1 = head_valid[1];
  assign o_cnt0   = cnt[0];
  assign o_cnt1   = cnt[1];

  a_level0_range : assert property (@(posedge i_clk) disable iff (!i_rst_n) level[0] != 2'd3);
  a_level1_range : assert property (@(posedge i_clk) disable iff (!i_rst_n) level[1] != 2'd3);
  a_no_push_full : assert property (@(posedge i_clk) disable iff (!i_rst_n) (push & full) == '0);

endmodule

// File: tb/tb_demux_2_stream.sv
// Directed bench for demux_2_stream: a vector table for reset, streaming and
// same-lane push/pop, then hand-written backpressure, isolation, reset and wrap sequences.
module tb_demux_2_stream;

  localparam int unsigned N  = 64;
  localparam int unsigned CW = 4;

  logic          i_clk;
  logic          i_rst_n;
  logic [N-1:0]  i_in;
  logic          i_s;
  logic          i_valid;
  logic          o_ready;
  logic [N-1:0]  o_out0;
  logic          o_valid0;
  logic          i_ready0;
  logic [N-1:0]  o_out1;
  logic          o_valid1;
  logic          i_ready1;
  logic [CW-1:0] o_cnt0;
  logic [CW-1:0] o_cnt1;

  int checks   = 0;
  int failures = 0;

  demux_2_stream #(.N(N), .CW(CW)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_in    (i_in),
    .i_s     (i_s),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_out0  (o_out0),
    .o_valid0(o_valid0),
    .i_ready0(i_ready0),
    .o_out1  (o_out1),
    .o_valid1(o_valid1),
    .i_ready1(i_ready1),
    .o_cnt0  (o_cnt0),
    .o_cnt1  (o_cnt1)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Inputs applied during one cycle, and the outputs expected before that cycle's edge.
  typedef struct {
    bit          chk;
    bit [1:0]    omask;
    bit          rst_n;
    bit          valid;
    bit          s;
    logic [63:0] din;
    bit          rdy0;
    bit          rdy1;
    bit          e_ready;
    bit          e_v0;
    logic [63:0] e_out0;
    bit          e_v1;
    logic [63:0] e_out1;
    logic [3:0]  e_c0;
    logic [3:0]  e_c1;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit rst_n, input bit valid, input bit s, input logic [63:0] din,
                       input bit rdy0, input bit rdy1);
    i_rst_n  = rst_n;
    i_valid  = valid;
    i_s      = s;
    i_in     = din;
    i_ready0 = rdy0;
    i_ready1 = rdy1;
    #1;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive(v.rst_n, v.valid, v.s, v.din, v.rdy0, v.rdy1);
    if (v.chk) begin
      check($sformatf("row%0d ready", idx), {63'd0, o_ready}, {63'd0, v.e_ready});
      check($sformatf("row%0d valid0", idx), {63'd0, o_valid0}, {63'd0, v.e_v0});
      check($sformatf("row%0d valid1", idx), {63'd0, o_valid1}, {63'd0, v.e_v1});
      check($sformatf("row%0d cnt0", idx), {60'd0, o_cnt0}, {60'd0, v.e_c0});
      check($sformatf("row%0d cnt1", idx), {60'd0, o_cnt1}, {60'd0, v.e_c1});
      if (v.omask[0]) check($sformatf("row%0d out0", idx), o_out0, v.e_out0);
      if (v.omask[1]) check($sformatf("row%0d out1", idx), o_out1, v.e_out1);
    end
    tick();
  endtask

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_s = 1'b0; i_in = '0; i_ready0 = 1'b0; i_ready1 = 1'b0;

    //          chk om rst v  s  din     r0 r1 rdy v0 out0 v1 out1    c0 c1
    // Reset held 3 cycles with traffic offered, then 0xA5 to lane 1.
    tbl[0]  = '{0, 0, 0, 1, 0, 64'h0,  1, 1, 1, 0, 0,   0, 0,      0, 0};
    tbl[1]  = '{1, 3, 0, 1, 1, 64'h0,  1, 1, 1, 0, 0,   0, 0,      0, 0};
    tbl[2]  = '{1, 3, 0, 1, 0, 64'h0,  1, 1, 1, 0, 0,   0, 0,      0, 0};
    tbl[3]  = '{1, 3, 1, 1, 1, 64'hA5, 1, 1, 1, 0, 0,   0, 0,      0, 0};
    tbl[4]  = '{1, 3, 1, 0, 0, 64'h0,  1, 1, 1, 0, 0,   1, 'hA5,   0, 1};
    // Alternating streaming, data 1..8, both consumers ready.
    tbl[5]  = '{1, 0, 1, 1, 0, 64'd1,  1, 1, 1, 0, 0,   0, 0,      0, 1};
    tbl[6]  = '{1, 1, 1, 1, 1, 64'd2,  1, 1, 1, 1, 1,   0, 0,      1, 1};
    tbl[7]  = '{1, 2, 1, 1, 0, 64'd3,  1, 1, 1, 0, 0,   1, 2,      1, 2};
    tbl[8]  = '{1, 1, 1, 1, 1, 64'd4,  1, 1, 1, 1, 3,   0, 0,      2, 2};
    tbl[9]  = '{1, 2, 1, 1, 0, 64'd5,  1, 1, 1, 0, 0,   1, 4,      2, 3};
    tbl[10] = '{1, 1, 1, 1, 1, 64'd6,  1, 1, 1, 1, 5,   0, 0,      3, 3};
    tbl[11] = '{1, 2, 1, 1, 0, 64'd7,  1, 1, 1, 0, 0,   1, 6,      3, 4};
    tbl[12] = '{1, 1, 1, 1, 1, 64'd8,  1, 1, 1, 1, 7,   0, 0,      4, 4};
    tbl[13] = '{1, 2, 1, 0, 0, 64'h0,  1, 1, 1, 0, 0,   1, 8,      4, 5};
    // Lane 1 at level 1, then push+pop on the same edge twice: no bubble.
    tbl[14] = '{1, 0, 1, 1, 1, 64'h30, 1, 0, 1, 0, 0,   0, 0,      4, 5};
    tbl[15] = '{1, 2, 1, 1, 1, 64'h31, 1, 1, 1, 0, 0,   1, 'h30,   4, 6};
    tbl[16] = '{1, 2, 1, 1, 1, 64'h32, 1, 1, 1, 0, 0,   1, 'h31,   4, 7};
    tbl[17] = '{1, 2, 1, 0, 0, 64'h0,  1, 1, 1, 0, 0,   1, 'h32,   4, 8};
    tbl[18] = '{1, 0, 1, 0, 0, 64'h0,  1, 1, 1, 0, 0,   0, 0,      4, 8};

    for (int i = 0; i < 19; i++) apply(tbl[i], i);

    // Backpressure on lane 0: two words fit, the third is held.
    drive(1, 1, 0, 64'h10, 0, 0);
    check("bp ready first", {63'd0, o_ready}, 64'd1);
    tick();
    drive(1, 1, 0, 64'h11, 0, 0);
    check("bp ready second", {63'd0, o_ready}, 64'd1);
    check("bp head after one", o_out0, 64'h10);
    tick();
    drive(1, 1, 0, 64'h12, 0, 0);
    check("bp ready full", {63'd0, o_ready}, 64'd0);
    check("bp cnt0 full", {60'd0, o_cnt0}, 64'd6);
    tick();

    // Lane isolation: lane 0 full, a lane 1 word still goes through.
    drive(1, 1, 1, 64'h20, 0, 0);
    check("iso ready lane1", {63'd0, o_ready}, 64'd1);
    tick();
    drive(1, 1, 0, 64'h12, 1, 0);
    check("iso valid1", {63'd0, o_valid1}, 64'd1);
    check("iso out1", o_out1, 64'h20);
    check("iso valid0 kept", {63'd0, o_valid0}, 64'd1);
    check("iso out0 kept", o_out0, 64'h10);
    check("iso ready lane0 still low", {63'd0, o_ready}, 64'd0);
    check("iso cnt1", {60'd0, o_cnt1}, 64'd9);
    tick();
    // The single-cycle pop of 0x10 above frees one slot.
    drive(1, 1, 0, 64'h12, 0, 0);
    check("bp ready after pop", {63'd0, o_ready}, 64'd1);
    check("bp head second", o_out0, 64'h11);
    tick();
    drive(1, 0, 0, 64'h0, 1, 0);
    check("bp cnt0 after 3", {60'd0, o_cnt0}, 64'd7);
    check("bp order 11", o_out0, 64'h11);
    tick();
    drive(1, 0, 0, 64'h0, 1, 0);
    check("bp order 12", o_out0, 64'h12);
    check("bp valid 12", {63'd0, o_valid0}, 64'd1);
    tick();
    drive(1, 0, 0, 64'h0, 0, 0);
    check("bp drained", {63'd0, o_valid0}, 64'd0);

    // Fill both lanes, then reset mid-operation.
    drive(1, 1, 1, 64'h21, 0, 0);
    tick();
    drive(1, 1, 0, 64'h40, 0, 0);
    tick();
    drive(1, 1, 0, 64'h41, 0, 0);
    tick();
    drive(0, 1, 0, 64'h42, 1, 1);
    check("pre-rst ready0 full", {63'd0, o_ready}, 64'd0);
    check("pre-rst cnt0", {60'd0, o_cnt0}, 64'd9);
    check("pre-rst cnt1", {60'd0, o_cnt1}, 64'd10);
    i_s = 1'b1;
    #1;
    check("pre-rst ready1 full", {63'd0, o_ready}, 64'd0);
    tick();
    drive(1, 0, 1, 64'h0, 0, 0);
    check("rst valid0", {63'd0, o_valid0}, 64'd0);
    check("rst valid1", {63'd0, o_valid1}, 64'd0);
    check("rst cnt0", {60'd0, o_cnt0}, 64'd0);
    check("rst cnt1", {60'd0, o_cnt1}, 64'd0);
    check("rst out0", o_out0, 64'd0);
    check("rst out1", o_out1, 64'd0);
    check("rst ready s1", {63'd0, o_ready}, 64'd1);
    i_s = 1'b0;
    #1;
    check("rst ready s0", {63'd0, o_ready}, 64'd1);

    // Counter wrap at CW=4: 17 pushes to lane 0 read 1..15, 0, 1.
    for (int i = 0; i < 17; i++) begin
      drive(1, 1, 0, 64'(i + 'h100), 1, 0);
      check($sformatf("wrap%0d ready", i), {63'd0, o_ready}, 64'd1);
      tick();
      check($sformatf("wrap%0d cnt0", i), {60'd0, o_cnt0}, 64'((i + 1) % 16));
      check($sformatf("wrap%0d head", i), o_out0, 64'(i + 'h100));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_2_stream.md
# demux_2_stream

Registered 1-to-2 stream demultiplexer, the counterpart of the two-input multiplexer: one N-bit input stream with valid/ready handshake, routed per word by a select bit to one of two output lanes. Each lane has its own 2-entry FIFO, so a stalled lane never blocks words bound for the other. Sits between the ALU result path and its two consumers: writeback and forwarding.

## Interface

- N, default 64: data width in bits.
- CW, default 32: width of the per-lane accepted-word counters.

- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  synchronous, active-low reset.
- i_in  input  N  input data word.
- i_s  input  1  lane select for the current word: 0 routes to lane 0, 1 routes to lane 1.
- i_valid  input  1  i_in and i_s are valid this cycle.
- o_ready  output  1  block accepts the offered word this cycle.
- o_out0  output  N  lane 0 head data.
- o_valid0  output  1  lane 0 head valid.
- i_ready0  input  1  lane 0 consumer accepts the head.
- o_out1  output  N  lane 1 head data.
- o_valid1  output  1  lane 1 head valid.
- i_ready1  input  1  lane 1 consumer accepts the head.
- o_cnt0  output  CW  count of words accepted into lane 0.
- o_cnt1  output  CW  count of words accepted into lane 1.

## Operation

- **Input handshake:** a word transfers when i_valid && o_ready.
- **o_ready:** combinational; o_ready = i_s ? !full1 : !full0.
  - Depends only on i_s and registered fill level.
  - Never depends on i_ready0, i_ready1 or i_valid.
- **Lane FIFO:** each lane is a 2-entry FIFO.
  - Storage: two N-bit registers, a 1-bit read pointer, a 1-bit write pointer and a 2-bit level (0, 1, 2).
  - full = (level == 2); o_validX = (level != 0).
  - o_outX = entry at the read pointer. It is the stored value even when level is 0; consumers must not sample it then.
- **Push:** lane X is pushed on an input transfer with i_s == X. The word is written at the write pointer, the write pointer toggles and level increments.
- **Pop:** lane X pops when o_validX && i_readyX. The read pointer toggles and level decrements.
- **Simultaneous push and pop on the same lane:**
  - level 1: level stays 1, both pointers toggle, order is preserved.
  - level 2: push is impossible because o_ready is low for that lane. Pop proceeds and level drops to 1.
  - level 0: pop is impossible because o_validX is low. There is no bypass; the pushed word appears the next cycle.
- **Lane independence:** a push to one lane and a pop from the other in the same cycle are independent.
- **Counters:** o_cntX increments by 1 on every push to lane X. It wraps modulo 2^CW from all-ones to 0 with no flag. Pops do not affect it.
- **Ordering:** within a lane, words are delivered in acceptance order. Relative order across lanes is not preserved.
- **Reset (i_rst_n low at a clock edge):**
  - Levels, pointers, counters and storage all clear to 0.
  - Any in-flight words are dropped and any handshake in that cycle is ignored.
  - Reset takes priority over push and pop.

## Timing

- **Reset values:**
  - o_valid0 = o_valid1 = 0.
  - o_out0 = o_out1 = 0.
  - o_cnt0 = o_cnt1 = 0.
  - o_ready = 1 for either value of i_s.
- **Latency:** a word accepted at edge t is visible on o_outX with o_validX = 1 after edge t, i.e. in cycle t+1, if the lane was empty.
- **Throughput:** 1 word/cycle per lane when the consumer holds i_readyX = 1. A 2-entry FIFO with registered level sustains this without a combinational ready path.
- **Backpressure:** with i_readyX = 0, lane X accepts exactly 2 words. o_ready is then low for i_s == X until the first pop; it rises in the cycle after that pop edge.
- **Counter timing:** o_cntX updates at the same edge as the push.
- **Boundary conditions:**
  - No combinational path exists from i_in to any output.
  - The only combinational input-to-output path is i_s to o_ready.

## Test plan

- **Reset:** hold i_rst_n = 0 for 3 cycles with i_valid = 1 and i_s toggling -> o_valid0 = o_valid1 = 0, o_cnt0 = o_cnt1 = 0, o_ready = 1. After release, the first word 0xA5 with i_s = 1 appears on o_out1 one cycle later.
- **Streaming:** alternate i_s 0,1,0,1 with data 1..8 and i_ready0 = i_ready1 = 1 -> lane 0 delivers 1,3,5,7 and lane 1 delivers 2,4,6,8, each one cycle after acceptance. o_ready stays 1 throughout. Final o_cnt0 = o_cnt1 = 4.
- **Backpressure:**
  - Setup: i_ready0 = 0; offer 0x10, 0x11, 0x12 all with i_s = 0.
  - Expect: two words accepted, then o_ready = 0 while 0x12 is held.
  - Then pulse i_ready0 for 1 cycle: 0x10 pops and o_ready rises the next cycle. Lane 0 later delivers 0x10, 0x11, 0x12 in order.
- **Lane isolation:** lane 0 full with i_ready0 = 0; offer 0x20 with i_s = 1 -> o_ready = 1 and 0x20 appears on o_out1. Lane 0 contents and o_valid0 are unchanged.
- **Same-lane push and pop:** with lane 1 at level 1, push and pop in the same cycle -> o_valid1 stays 1, level stays 1, and o_out1 advances to the new word with no bubble.
- **Wrap and mid-operation reset:**
  - Wrap: with CW = 4, push 17 words to lane 0 -> o_cnt0 reads 15 then 0 then 1.
  - Reset: assert i_rst_n = 0 with both lanes full -> the next cycle shows both valids 0, both counters 0 and o_ready = 1.
